// File: rtl/fetch_module.sv
// Instruction-fetch stage: program counter, word-addressed instruction memory
// with a load port, and the IF/ID pipeline register that feeds decode.
module fetch_module #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        imem_we,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic [31:0] id_pc_plus_4,
    output logic        id_valid,
    output logic        addr_error
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    logic [31:0]   mem [IMEM_DEPTH];

    logic [31:0]   pc_plus_4;
    logic [31:0]   pc_next;
    logic [31:0]   fetch_word;
    logic          fetch_in_range;
    logic          redirect;
    logic          target_misaligned;
    logic          wr_ok;
    logic [AW-1:0] fetch_idx;
    logic [AW-1:0] wr_idx;

    assign pc_plus_4         = pc + 32'd4;
    assign fetch_idx         = pc[AW+1:2];
    assign wr_idx            = imem_addr[AW+1:2];
    assign fetch_in_range    = (pc >> (AW + 2)) == '0;
    assign redirect          = branch_taken | jump;
    assign target_misaligned = branch_target[1:0] != 2'b00;
    assign wr_ok             = imem_we && (imem_addr[1:0] == 2'b00) &&
                               ((imem_addr >> (AW + 2)) == '0);

    // Combinational read: a same-edge write is only visible on the next fetch.
    always_comb begin
        fetch_word = NOP_WORD;
        if (fetch_in_range) begin
            fetch_word = mem[fetch_idx];
        end
    end

    always_comb begin
        pc_next = pc_plus_4;
        if (branch_taken) begin
            pc_next = {branch_target[31:2], 2'b00};
        end else if (jump) begin
            pc_next = {id_pc_plus_4[31:28], jump_index, 2'b00};
        end else if (stall) begin
            pc_next = pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction  <= NOP_WORD;
            id_pc_plus_4 <= '0;
            id_valid     <= 1'b0;
        end else if (flush || redirect) begin
            instruction <= NOP_WORD;
            id_valid    <= 1'b0;
        end else if (!stall) begin
            instruction  <= fetch_word;
            id_pc_plus_4 <= pc_plus_4;
            id_valid     <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_error <= 1'b0;
        end else if (!fetch_in_range || (branch_taken && target_misaligned)) begin
            addr_error <= 1'b1;
        end
    end

    // Memory is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= imem_wdata;
        end
    end

endmodule

// File: tb/tb_fetch_module.sv
// Self-checking bench for fetch_module: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_fetch_module;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] id_pc_plus_4;
    logic        id_valid;
    logic        addr_error;

    int unsigned vectors;
    int unsigned miscompares;

    // Reference model state
    logic [31:0] m_mem [256];
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    logic [31:0] m_pp4;
    logic        m_val;
    logic        m_err;

    fetch_module #(
        .IMEM_DEPTH(256),
        .RESET_PC  (32'h0000_0000),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_index   (jump_index),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .pc           (pc),
        .instruction  (instruction),
        .id_pc_plus_4 (id_pc_plus_4),
        .id_valid     (id_valid),
        .addr_error   (addr_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle();
        stall = 0; flush = 0; branch_taken = 0; branch_target = '0;
        jump = 0; jump_index = '0; imem_we = 0; imem_addr = '0; imem_wdata = '0;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ins = 32'h0; m_pp4 = 32'h0; m_val = 0; m_err = 0;
    endtask

    // Advance the model by one edge from the currently driven inputs, then
    // wait for that edge and settle 1 time unit past it.
    task automatic tick();
        logic [31:0] fetched;
        logic [31:0] npc;
        logic        nerr;
        if (!rst_n) begin
            model_reset();
        end else begin
            fetched = (m_pc < 32'd1024) ? m_mem[m_pc[9:2]] : 32'h0;
            nerr = m_err | (m_pc >= 32'd1024) | (branch_taken && (branch_target[1:0] != 2'b00));
            if (branch_taken)  npc = {branch_target[31:2], 2'b00};
            else if (jump)     npc = {m_pp4[31:28], jump_index, 2'b00};
            else if (stall)    npc = m_pc;
            else               npc = m_pc + 32'd4;
            if (flush || branch_taken || jump) begin
                m_ins = 32'h0; m_val = 0;
            end else if (!stall) begin
                m_ins = fetched; m_pp4 = m_pc + 32'd4; m_val = 1;
            end
            m_pc = npc;
            m_err = nerr;
        end
        if (imem_we && (imem_addr[1:0] == 2'b00) && (imem_addr < 32'd1024))
            m_mem[imem_addr[9:2]] = imem_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #2;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        model_reset();
        #3;
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h want %h", pc, 32'h0); end
        vectors++; if (instruction !== 32'h0) begin miscompares++; $display("FAIL rst_ins got %h want %h", instruction, 32'h0); end
        vectors++; if (id_pc_plus_4 !== 32'h0) begin miscompares++; $display("FAIL rst_pp4 got %h want %h", id_pc_plus_4, 32'h0); end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", id_valid); end
        vectors++; if (addr_error !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", addr_error); end
        for (int i = 0; i < 256; i++) begin
            imem_we = 1;
            imem_addr = 32'(i) << 2;
            imem_wdata = (i < 4) ? 32'(11 * (i + 1)) : $urandom;
            tick();
        end
        idle();
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL rst_hold_pc got %h want %h", pc, 32'h0); end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL rst_hold_valid got %b want 0", id_valid); end
        rst_n = 1;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++; if (instruction !== 32'(11 * (k + 1))) begin miscompares++; $display("FAIL stream_ins[%0d] got %0d want %0d", k, instruction, 11 * (k + 1)); end
            vectors++; if (id_pc_plus_4 !== 32'(4 * (k + 1))) begin miscompares++; $display("FAIL stream_pp4[%0d] got %h want %h", k, id_pc_plus_4, 4 * (k + 1)); end
            vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d] got %b want 1", k, id_valid); end
            vectors++; if (pc !== 32'(4 * (k + 1))) begin miscompares++; $display("FAIL stream_pc[%0d] got %h want %h", k, pc, 4 * (k + 1)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL stall_pc[%0d] got %h want %h", k, pc, 32'h8); end
            vectors++; if (instruction !== 32'd22) begin miscompares++; $display("FAIL stall_ins[%0d] got %0d want 22", k, instruction); end
            vectors++; if (id_pc_plus_4 !== 32'h8) begin miscompares++; $display("FAIL stall_pp4[%0d] got %h want %h", k, id_pc_plus_4, 32'h8); end
        end
        stall = 0;
        tick();
        vectors++; if (instruction !== 32'd33) begin miscompares++; $display("FAIL stall_resume_ins got %0d want 33", instruction); end
        vectors++; if (id_pc_plus_4 !== 32'hC) begin miscompares++; $display("FAIL stall_resume_pp4 got %h want %h", id_pc_plus_4, 32'hC); end
    endtask

    task automatic test_branch();
        for (int rep = 0; rep < 2; rep++) begin
            do_reset();
            tick();
            tick();
            branch_taken = 1; branch_target = 32'h40; stall = (rep == 1);
            tick();
            vectors++; if (pc !== 32'h40) begin miscompares++; $display("FAIL br_pc[%0d] got %h want %h", rep, pc, 32'h40); end
            vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL br_bubble_valid[%0d] got %b want 0", rep, id_valid); end
            vectors++; if (instruction !== 32'h0) begin miscompares++; $display("FAIL br_bubble_ins[%0d] got %h want 0", rep, instruction); end
            vectors++; if (id_pc_plus_4 !== 32'h8) begin miscompares++; $display("FAIL br_bubble_pp4[%0d] got %h want %h", rep, id_pc_plus_4, 32'h8); end
            idle();
            tick();
            vectors++; if (instruction !== m_mem[16]) begin miscompares++; $display("FAIL br_target_ins[%0d] got %h want %h", rep, instruction, m_mem[16]); end
            vectors++; if (id_pc_plus_4 !== 32'h44) begin miscompares++; $display("FAIL br_target_pp4[%0d] got %h want %h", rep, id_pc_plus_4, 32'h44); end
            vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL br_target_valid[%0d] got %b want 1", rep, id_valid); end
        end
    endtask

    task automatic test_jump();
        do_reset();
        branch_taken = 1; branch_target = 32'h1000_0004;
        tick();
        idle();
        tick();
        vectors++; if (id_pc_plus_4 !== 32'h1000_0008) begin miscompares++; $display("FAIL jmp_setup_pp4 got %h want %h", id_pc_plus_4, 32'h1000_0008); end
        jump = 1; jump_index = 26'h10;
        tick();
        idle();
        vectors++; if (pc !== 32'h1000_0040) begin miscompares++; $display("FAIL jmp_pc got %h want %h", pc, 32'h1000_0040); end
        tick();
        vectors++; if (instruction !== 32'h0) begin miscompares++; $display("FAIL jmp_oor_ins got %h want 0", instruction); end
        vectors++; if (addr_error !== 1'b1) begin miscompares++; $display("FAIL jmp_oor_err got %b want 1", addr_error); end
    endtask

    task automatic test_wrap();
        do_reset();
        vectors++; if (addr_error !== 1'b0) begin miscompares++; $display("FAIL wrap_err_cleared got %b want 0", addr_error); end
        branch_taken = 1; branch_target = 32'hFFFF_FFFC;
        tick();
        idle();
        tick();
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL wrap_pc got %h want 0", pc); end
        vectors++; if (id_pc_plus_4 !== 32'h0) begin miscompares++; $display("FAIL wrap_pp4 got %h want 0", id_pc_plus_4); end
    endtask

    task automatic test_misaligned();
        do_reset();
        vectors++; if (addr_error !== 1'b0) begin miscompares++; $display("FAIL mis_err_pre got %b want 0", addr_error); end
        branch_taken = 1; branch_target = 32'h22;
        tick();
        idle();
        vectors++; if (pc !== 32'h20) begin miscompares++; $display("FAIL mis_pc got %h want %h", pc, 32'h20); end
        vectors++; if (addr_error !== 1'b1) begin miscompares++; $display("FAIL mis_err got %b want 1", addr_error); end
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++; if (addr_error !== 1'b1) begin miscompares++; $display("FAIL mis_sticky[%0d] got %b want 1", k, addr_error); end
        end
        #2;
        rst_n = 0;
        #1;
        vectors++; if (addr_error !== 1'b0) begin miscompares++; $display("FAIL mis_err_rst got %b want 0", addr_error); end
        tick();
        rst_n = 1;
    endtask

    task automatic test_async_reset();
        do_reset();
        tick();
        tick();
        tick();
        #2;
        rst_n = 0;
        #1;
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL arst_pc got %h want 0", pc); end
        vectors++; if (instruction !== 32'h0) begin miscompares++; $display("FAIL arst_ins got %h want 0", instruction); end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid got %b want 0", id_valid); end
        vectors++; if (id_pc_plus_4 !== 32'h0) begin miscompares++; $display("FAIL arst_pp4 got %h want 0", id_pc_plus_4); end
        tick();
        rst_n = 1;
        tick();
        vectors++; if (instruction !== 32'd11) begin miscompares++; $display("FAIL arst_mem0 got %0d want 11", instruction); end
        tick();
        vectors++; if (instruction !== 32'd22) begin miscompares++; $display("FAIL arst_mem1 got %0d want 22", instruction); end
        vectors++; if (id_pc_plus_4 !== 32'h8) begin miscompares++; $display("FAIL arst_pp4_1 got %h want %h", id_pc_plus_4, 32'h8); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 0) begin
                idle();
                do_reset();
            end
            stall         = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_target = $urandom_range(0, 1100);
            jump          = ($urandom_range(0, 15) == 0);
            jump_index    = 26'($urandom_range(0, 300));
            imem_we       = ($urandom_range(0, 3) == 0);
            imem_addr     = ($urandom_range(0, 1)) ? m_pc : $urandom_range(0, 1100);
            imem_wdata    = $urandom;
            tick();
            vectors++; if (pc !== m_pc) begin miscompares++; $display("FAIL rnd_pc[%0d] got %h want %h", i, pc, m_pc); end
            vectors++; if (instruction !== m_ins) begin miscompares++; $display("FAIL rnd_ins[%0d] got %h want %h", i, instruction, m_ins); end
            vectors++; if (id_pc_plus_4 !== m_pp4) begin miscompares++; $display("FAIL rnd_pp4[%0d] got %h want %h", i, id_pc_plus_4, m_pp4); end
            vectors++; if (id_valid !== m_val) begin miscompares++; $display("FAIL rnd_valid[%0d] got %b want %b", i, id_valid, m_val); end
            vectors++; if (addr_error !== m_err) begin miscompares++; $display("FAIL rnd_err[%0d] got %b want %b", i, addr_error, m_err); end
        end
        idle();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_jump();
        test_wrap();
        test_misaligned();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
